mau_arbiter: RTL and testbench



---
 rtl/mau_arb_pkg.sv | 13 +
 rtl/mau_rr_pick.sv | 34 +++
 rtl/mau_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_mau_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mau_arb_pkg.sv
// Shared types for the MAU arbiter: FSM state encoding, statistics width
// and a saturating increment used by the optional MAU_ARB_STATS_EN counters.
package mau_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RELEASE} arb_state_t;

  localparam int STAT_W = 32;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mau_rr_pick.sv
// Combinational round-robin picker: first set request bit searching upward
// from ptr+1, wrapping modulo NUM_REQ.
module mau_rr_pick #(
  parameter int NUM_REQ = 2,
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any
);

  logic found;
  int   cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = (int'(ptr) + i) % NUM_REQ;
      if (!found && req[IDX_W'(cand)]) begin
        found                 = 1'b1;
        grant[IDX_W'(cand)]   = 1'b1;
        grant_idx             = IDX_W'(cand);
      end
    end
  end

  assign any = found;

endmodule

// File: rtl/mau_arbiter.sv
// Round-robin arbiter sharing one MAU between NUM_REQ requesters, one
// transaction in flight. Optional counters are built with MAU_ARB_STATS_EN.
// Handshake: a requester holds req_valid (with write/addr/wdata stable) until it
// sees req_ready, a one-cycle grant pulse meaning the request was latched;
// rsp_valid pulses once per granted request on completion.
module mau_arbiter
  import mau_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      busy,
  output logic                      access_enable,
  output logic                      read_enable,
  output logic                      write_enable,
  output logic [ADDR_W-1:0]         access_addr,
  output logic [DATA_W-1:0]         write_data,
  input  logic [DATA_W-1:0]         read_data,
  input  logic                      data_valid,
  input  logic                      write_done,
`ifdef MAU_ARB_STATS_EN
  output logic [NUM_REQ*STAT_W-1:0] stat_grants,
  output logic [STAT_W-1:0]         stat_busy_cycles,
  output logic [STAT_W-1:0]         stat_contention,
`endif
  output arb_state_t                dbg_state
);

  arb_state_t state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d, owner_q, owner_d;
  logic               wr_q, wr_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d, rsp_rdata_q, rsp_rdata_d;
  logic [NUM_REQ-1:0] req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d;
  logic               busy_q, busy_d, acc_en_q, acc_en_d;
  logic               rd_en_q, rd_en_d, wr_en_q, wr_en_d;

  logic [NUM_REQ-1:0] pick_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic               done;

  mau_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (pick_grant),
    .grant_idx (pick_idx),
    .any       (pick_any)
  );

  // Completion flags are sticky in the MAU; they are only trusted in WAIT.
  assign done = wr_q ? write_done : data_valid;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_any) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (done) state_d = RELEASE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from state_d, so req_ready and access_enable both
  // appear in the ISSUE cycle, one cycle after the arbitration decision.
  always_comb begin
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    req_ready_d = '0;
    rsp_valid_d = '0;
    if (state_q == IDLE && pick_any) begin
      req_ready_d = pick_grant;
      owner_d     = pick_idx;
      ptr_d       = pick_idx;
      wr_d        = req_write[pick_idx];
      for (int i = 0; i < NUM_REQ; i++) begin
        if (pick_grant[i]) begin
          addr_d  = req_addr[i*ADDR_W +: ADDR_W];
          wdata_d = req_wdata[i*DATA_W +: DATA_W];
        end
      end
    end
    if (state_q == WAIT && done) begin
      rsp_valid_d[owner_q] = 1'b1;
      if (!wr_q) rsp_rdata_d = read_data;
    end
    busy_d   = (state_d != IDLE);
    acc_en_d = (state_d == ISSUE) || (state_d == WAIT);
    rd_en_d  = acc_en_d & ~wr_d;
    wr_en_d  = acc_en_d &  wr_d;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr_q       <= IDX_W'(NUM_REQ - 1);
      owner_q     <= '0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_rdata_q <= '0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      busy_q      <= 1'b0;
      acc_en_q    <= 1'b0;
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
      acc_en_q    <= acc_en_d;
      rd_en_q     <= rd_en_d;
      wr_en_q     <= wr_en_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign busy          = busy_q;
  assign access_enable = acc_en_q;
  assign read_enable   = rd_en_q;
  assign write_enable  = wr_en_q;
  assign access_addr   = addr_q;
  assign write_data    = wdata_q;
  assign dbg_state     = state_q;

`ifdef MAU_ARB_STATS_EN
  logic [NUM_REQ*STAT_W-1:0] grants_q, grants_d;
  logic [STAT_W-1:0]         busy_cnt_q, busy_cnt_d, cont_q, cont_d;

  always_comb begin
    grants_d   = grants_q;
    busy_cnt_d = busy_q ? sat_inc(busy_cnt_q) : busy_cnt_q;
    cont_d     = (state_q == IDLE && $countones(req_valid) > 1) ? sat_inc(cont_q) : cont_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready_d[i]) grants_d[i*STAT_W +: STAT_W] = sat_inc(grants_q[i*STAT_W +: STAT_W]);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      grants_q   <= '0;
      busy_cnt_q <= '0;
      cont_q     <= '0;
    end else begin
      grants_q   <= grants_d;
      busy_cnt_q <= busy_cnt_d;
      cont_q     <= cont_d;
    end
  end

  assign stat_grants      = grants_q;
  assign stat_busy_cycles = busy_cnt_q;
  assign stat_contention  = cont_q;
`endif

endmodule

// File: tb/tb_mau_arbiter.sv
// Directed bench for mau_arbiter with a behavioural sticky-flag MAU model.
// Counter checks are compiled in when MAU_ARB_STATS_EN is defined.
module tb_mau_arbiter;
  import mau_arb_pkg::*;

  logic        clk, resetn;
  logic [1:0]  req_valid, req_write, req_ready, rsp_valid;
  logic [63:0] req_addr, req_wdata;
  logic [31:0] rsp_rdata, access_addr, write_data, read_data;
  logic        busy, access_enable, read_enable, write_enable;
  logic        data_valid, write_done;
  arb_state_t  dbg_state;
`ifdef MAU_ARB_STATS_EN
  logic [63:0] stat_grants;
  logic [31:0] stat_busy_cycles, stat_contention;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  mau_arbiter dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .access_enable(access_enable), .read_enable(read_enable), .write_enable(write_enable),
    .access_addr(access_addr), .write_data(write_data), .read_data(read_data),
    .data_valid(data_valid), .write_done(write_done),
`ifdef MAU_ARB_STATS_EN
    .stat_grants(stat_grants), .stat_busy_cycles(stat_busy_cycles), .stat_contention(stat_contention),
`endif
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // MAU model: launch on access_enable from idle clears the matching sticky flag
  int          mau_lat = 3;
  logic [31:0] mau_rval = 32'h0;
  int          mau_cnt;
  logic [1:0]  mau_st;
  logic        mau_wr;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mau_st <= 2'd0; mau_cnt <= 0; mau_wr <= 1'b0;
      data_valid <= 1'b0; write_done <= 1'b0; read_data <= 32'h0;
    end else begin
      case (mau_st)
        2'd0: if (access_enable) begin
          mau_st <= 2'd1; mau_cnt <= mau_lat - 1; mau_wr <= write_enable;
          if (read_enable)  data_valid <= 1'b0;
          if (write_enable) write_done <= 1'b0;
        end
        2'd1: if (mau_cnt == 0) begin
          mau_st <= 2'd2;
          if (mau_wr) write_done <= 1'b1;
          else begin data_valid <= 1'b1; read_data <= mau_rval; end
        end else mau_cnt <= mau_cnt - 1;
        default: if (!access_enable) mau_st <= 2'd0;
      endcase
    end
  end

  // scoreboard: grant log sampled mid-cycle, away from both clock edges
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         got_t[$];
  int         cyc_n = 0;
  int         rsp_cnt = 0;
  bit         both_en = 1'b0;
  bit         rd_seen = 1'b0;

  always begin
    @(posedge clk);
    #2;
    cyc_n++;
    if (resetn) begin
      for (int i = 0; i < 2; i++) begin
        if (req_ready[i]) begin
          got_q.push_back(8'(i));
          got_t.push_back(cyc_n);
        end
      end
      if (rsp_valid != 2'b00) rsp_cnt++;
      if (read_enable && write_enable) both_en = 1'b1;
      if (read_enable) rd_seen = 1'b1;
    end
  end

  // driver tasks
  task automatic set_req(input int i, input bit v, input bit w,
                         input logic [31:0] a, input logic [31:0] d);
    req_valid[i] = v;
    req_write[i] = w;
    req_addr[i*32 +: 32]  = a;
    req_wdata[i*32 +: 32] = d;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  // returns at the negedge where req_ready[i] is visible (the ISSUE cycle)
  task automatic start_req(input int i, input bit w, input logic [31:0] a,
                           input logic [31:0] d, output bit ok);
    set_req(i, 1'b1, w, a, d);
    ok = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (req_ready[i]) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_rsp(input int idx, input int max_c, output int cyc);
    cyc = -1;
    for (int c = 1; c <= max_c; c++) begin
      @(negedge clk);
      if (rsp_valid[idx]) begin cyc = c; break; end
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if ({req_ready, rsp_valid, busy, access_enable, read_enable, write_enable} !== 8'h00 ||
        access_addr !== 32'h0 || write_data !== 32'h0 || rsp_rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: rdy=%b rsp=%b busy=%b en=%b%b%b addr=%h wd=%h rd=%h, want all 0",
               req_ready, rsp_valid, busy, access_enable, read_enable, write_enable,
               access_addr, write_data, rsp_rdata);
    end
    tests_run++;
    if (dbg_state !== IDLE) begin
      tests_failed++; $display("FAIL reset_state: got %0d want IDLE", dbg_state);
    end
  endtask

  task automatic test_single_read();
    bit ok; int c;
    mau_lat = 3; mau_rval = 32'hDEADBEEF;
    start_req(0, 1'b0, 32'h100, 32'h0, ok);
    set_req(0, 1'b0, 1'b0, 32'h100, 32'h0);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL read_grant: no req_ready[0] within bound"); end
    tests_run++;
    if (req_ready !== 2'b01 || access_enable !== 1'b1 || read_enable !== 1'b1 ||
        write_enable !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL read_issue: rdy=%b en=%b rd=%b wr=%b busy=%b, want 01 1 1 0 1",
               req_ready, access_enable, read_enable, write_enable, busy);
    end
    tests_run++;
    if (access_addr !== 32'h100) begin
      tests_failed++; $display("FAIL read_addr: got %h want 00000100", access_addr);
    end
    wait_rsp(0, 20, c);
    tests_run++;
    if (c !== 5) begin tests_failed++; $display("FAIL read_latency: got %0d want 5", c); end
    tests_run++;
    if (rsp_valid !== 2'b01 || rsp_rdata !== 32'hDEADBEEF || access_enable !== 1'b0) begin
      tests_failed++;
      $display("FAIL read_rsp: rsp=%b data=%h en=%b, want 01 deadbeef 0", rsp_valid, rsp_rdata, access_enable);
    end
    @(negedge clk);
    tests_run++;
    if (rsp_valid !== 2'b00 || busy !== 1'b0 || rsp_rdata !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL read_after: rsp=%b busy=%b data=%h, want 00 0 deadbeef", rsp_valid, busy, rsp_rdata);
    end
  endtask

  task automatic test_single_write();
    bit ok; int c;
    mau_lat = 3;
    rd_seen = 1'b0;
    start_req(1, 1'b1, 32'h200, 32'h12345678, ok);
    set_req(1, 1'b0, 1'b1, 32'h200, 32'h12345678);
    tests_run++;
    if (!ok || req_ready !== 2'b10 || write_enable !== 1'b1 || read_enable !== 1'b0 ||
        access_addr !== 32'h200 || write_data !== 32'h12345678) begin
      tests_failed++;
      $display("FAIL write_issue: ok=%0d rdy=%b wr=%b rd=%b addr=%h wd=%h, want 1 10 1 0 200 12345678",
               ok, req_ready, write_enable, read_enable, access_addr, write_data);
    end
    wait_rsp(1, 20, c);
    tests_run++;
    if (c !== 5 || rsp_valid !== 2'b10) begin
      tests_failed++; $display("FAIL write_rsp: cycles=%0d rsp=%b, want 5 10", c, rsp_valid);
    end
    tests_run++;
    if (rd_seen !== 1'b0) begin
      tests_failed++; $display("FAIL write_no_read: read_enable seen=%0d want 0", rd_seen);
    end
  endtask

  task automatic test_stale_flag();
    bit ok; int c;
    mau_lat = 2; mau_rval = 32'h11111111;
    @(negedge clk);
    start_req(0, 1'b0, 32'h300, 32'h0, ok);
    set_req(0, 1'b0, 1'b0, 32'h300, 32'h0);
    wait_rsp(0, 20, c);
    tests_run++;
    if (!ok || c !== 4 || rsp_rdata !== 32'h11111111) begin
      tests_failed++; $display("FAIL stale_first: ok=%0d cycles=%0d data=%h, want 1 4 11111111", ok, c, rsp_rdata);
    end
    // data_valid is still high from the read above when the next read issues
    mau_lat = 5; mau_rval = 32'hCAFEF00D;
    start_req(0, 1'b0, 32'h304, 32'h0, ok);
    set_req(0, 1'b0, 1'b0, 32'h304, 32'h0);
    wait_rsp(0, 20, c);
    tests_run++;
    if (!ok || c !== 7 || rsp_rdata !== 32'hCAFEF00D) begin
      tests_failed++; $display("FAIL stale_second: ok=%0d cycles=%0d data=%h, want 1 7 cafef00d", ok, c, rsp_rdata);
    end
  endtask

  task automatic test_contention();
    int c; int n;
    do_reset();
    mau_lat = 3; mau_rval = 32'h5A5A5A5A;
    got_q.delete(); got_t.delete();
    exp_q = '{8'd0, 8'd1, 8'd0, 8'd1, 8'd0, 8'd1};
    set_req(0, 1'b1, 1'b0, 32'h400, 32'h0);
    set_req(1, 1'b1, 1'b0, 32'h500, 32'h0);
    for (int k = 0; k < 200 && got_q.size() < 6; k++) @(negedge clk);
    req_valid = 2'b00;
    tests_run++;
    if (got_q.size() < 6) begin
      tests_failed++; $display("FAIL contention_count: got %0d grants want 6", got_q.size());
    end
    n = (got_q.size() < 6) ? got_q.size() : 6;
    for (int i = 0; i < n; i++) begin
      tests_run++;
      if (got_q[i] !== exp_q[i]) begin
        tests_failed++; $display("FAIL contention_order[%0d]: got %0d want %0d", i, got_q[i], exp_q[i]);
      end
    end
    if (n >= 2) begin
      tests_run++;
      if (got_t[1] - got_t[0] !== 7) begin
        tests_failed++; $display("FAIL grant_spacing: got %0d want 7", got_t[1] - got_t[0]);
      end
    end
    wait_rsp(1, 20, c);
    @(negedge clk);
`ifdef MAU_ARB_STATS_EN
    tests_run++;
    if (stat_grants !== {32'd3, 32'd3} || stat_contention !== 32'd6 || stat_busy_cycles !== 32'd36) begin
      tests_failed++;
      $display("FAIL stats: grants=%h cont=%0d busy=%0d, want 0000000300000003 6 36",
               stat_grants, stat_contention, stat_busy_cycles);
    end
`endif
  endtask

  task automatic test_withdraw();
    bit ok; int c;
    got_q.delete();
    mau_lat = 3;
    start_req(0, 1'b0, 32'h600, 32'h0, ok);
    set_req(0, 1'b0, 1'b0, 32'h600, 32'h0);
    set_req(1, 1'b1, 1'b0, 32'h700, 32'h0);
    @(negedge clk);
    set_req(1, 1'b0, 1'b0, 32'h700, 32'h0);
    wait_rsp(0, 20, c);
    repeat (4) @(negedge clk);
    tests_run++;
    if (!ok || got_q.size() !== 1 || got_q[0] !== 8'd0) begin
      tests_failed++; $display("FAIL withdraw: ok=%0d grants=%0d, want 1 grant to req 0", ok, got_q.size());
    end
  endtask

  task automatic test_reset_in_wait();
    bit ok; int c;
    mau_lat = 10;
    start_req(0, 1'b0, 32'h800, 32'h0, ok);
    set_req(0, 1'b0, 1'b0, 32'h800, 32'h0);
    repeat (2) @(negedge clk);
    resetn = 1'b0;
    #1;
    tests_run++;
    if ({req_ready, rsp_valid, busy, access_enable, read_enable, write_enable} !== 8'h00 ||
        access_addr !== 32'h0 || dbg_state !== IDLE) begin
      tests_failed++;
      $display("FAIL reset_wait_outputs: rdy=%b rsp=%b busy=%b en=%b%b%b addr=%h st=%0d, want 0",
               req_ready, rsp_valid, busy, access_enable, read_enable, write_enable, access_addr, dbg_state);
    end
    @(negedge clk);
    resetn = 1'b1;
    rsp_cnt = 0;
    repeat (15) @(negedge clk);
    tests_run++;
    if (rsp_cnt !== 0) begin
      tests_failed++; $display("FAIL reset_wait_no_rsp: got %0d pulses want 0", rsp_cnt);
    end
    mau_lat = 3;
    got_q.delete();
    set_req(0, 1'b1, 1'b0, 32'h900, 32'h0);
    set_req(1, 1'b1, 1'b0, 32'hA00, 32'h0);
    for (int k = 0; k < 12 && got_q.size() < 1; k++) @(negedge clk);
    req_valid = 2'b00;
    tests_run++;
    if (got_q.size() < 1 || got_q[0] !== 8'd0) begin
      tests_failed++;
      $display("FAIL reset_wait_winner: grants=%0d first=%0d want req 0",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hFF);
    end
    wait_rsp(0, 20, c);
  endtask

  task automatic test_exclusive_enables();
    tests_run++;
    if (both_en !== 1'b0) begin
      tests_failed++; $display("FAIL exclusive_enables: both high seen=%0d want 0", both_en);
    end
  endtask

  initial begin
    resetn = 1'b0;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    @(negedge clk);
    test_reset();
    test_single_read();
    test_single_write();
    test_stale_flag();
    test_contention();
    test_withdraw();
    test_reset_in_wait();
    test_exclusive_enables();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
